// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: bus widths, opcodes, channel structs and the
// per-request bookkeeping record kept by device-side adapters.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_UW  = 4;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic [TL_UW-1:0]  a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic [TL_UW-1:0]  d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  typedef struct packed {
    logic [2:0]        d_opcode;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic [TL_DW-1:0]  data;
    logic              err;
  } rsp_entry_t;

  // Byte lanes a naturally aligned access of the given size touches.
  function automatic logic [TL_DBW-1:0] lane_mask(input logic [TL_SZW-1:0] size,
                                                  input logic [1:0] offset);
    logic [TL_DBW-1:0] base;
    case (size)
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/tlul_rsp_buf.sv
// Circular response buffer: holds accepted requests in order, completes the
// oldest one still waiting on the device, and releases finished ones at the head.
module tlul_rsp_buf
  import tlul_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic             clock,
  input  logic             rst_ni,
  input  logic             push,
  input  rsp_entry_t       push_entry,
  input  logic             push_done,
  input  logic             complete,
  input  logic [TL_DW-1:0] complete_data,
  input  logic             complete_err,
  input  logic             pop,
  output logic             full,
  output logic             pending,
  output logic             head_done,
  output rsp_entry_t       head_entry
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;

  rsp_entry_t       entries [Depth];
  logic [Depth-1:0] done_q;
  logic [PW-1:0]    wr_ptr, rd_ptr, count;
  logic [AW-1:0]    wr_idx, rd_idx, scan_idx, cmp_idx;
  logic             push_ok, cmp_ok, pop_ok, empty;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  assign head_done  = ~empty & done_q[rd_idx];
  assign head_entry = entries[rd_idx];

  assign push_ok = push & ~full;
  assign cmp_ok  = complete & pending;
  assign pop_ok  = pop & head_done;

  // The device answers in grant order, so the first occupied, unfinished
  // slot after the head is always the one it is answering.
  always_comb begin
    pending  = 1'b0;
    cmp_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      scan_idx = rd_idx + AW'(i);
      if (!pending && (PW'(i) < count) && !done_q[scan_idx]) begin
        pending = 1'b1;
        cmp_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      done_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr         <= wr_ptr + PW'(1);
        done_q[wr_idx] <= push_done;
      end
      if (cmp_ok) begin
        done_q[cmp_idx] <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Payload needs no reset: nothing is visible unless its done flag is set.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      entries[wr_idx] <= push_entry;
    end
    if (cmp_ok) begin
      entries[cmp_idx].data <= (entries[cmp_idx].d_opcode == AccessAckData) ? complete_data : '0;
      entries[cmp_idx].err  <= complete_err;
    end
  end

endmodule

// File: rtl/tlul_device_adapter.sv
// TL-UL responder in front of a req/gnt/rvalid device: screens A-channel
// requests, forwards legal ones and returns in-order D-channel responses.
module tlul_device_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic              clock,
  input  logic              rst_ni,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [TL_AW-1:0]  addr_o,
  output logic [TL_DW-1:0]  wdata_o,
  output logic [TL_DBW-1:0] be_o,
  input  logic              rvalid_i,
  input  logic [TL_DW-1:0]  rdata_i,
  input  logic              err_i
);

  logic              is_get, is_put_full, is_put_partial;
  logic              op_ok, size_ok, align_ok, mask_ok, bad;
  logic [TL_DBW-1:0] lanes;
  logic              full, pending, head_done, a_ready, d_valid, push, pop;
  logic              unused_fields;
  rsp_entry_t        push_entry, head_entry;

  assign is_get         = (tl_i.a_opcode == Get);
  assign is_put_full    = (tl_i.a_opcode == PutFullData);
  assign is_put_partial = (tl_i.a_opcode == PutPartialData);
  assign op_ok          = is_get | is_put_full | is_put_partial;
  assign size_ok        = (tl_i.a_size <= 2'd2);

  always_comb begin
    case (tl_i.a_size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = ~tl_i.a_address[0];
      default: align_ok = (tl_i.a_address[1:0] == 2'b00);
    endcase
  end

  assign lanes   = lane_mask(tl_i.a_size, tl_i.a_address[1:0]);
  assign mask_ok = ~|(tl_i.a_mask & ~lanes) & (~is_put_full | (tl_i.a_mask == lanes));
  assign bad     = ~(op_ok & size_ok & align_ok & mask_ok);

  // Erroneous requests never reach the device and are acknowledged locally,
  // so only legal ones have to wait for a grant.
  assign req_o   = rst_ni & tl_i.a_valid & ~full & ~bad;
  assign a_ready = rst_ni & ~full & (bad | gnt_i);
  assign push    = tl_i.a_valid & a_ready;

  assign we_o    = is_put_full | is_put_partial;
  assign addr_o  = {tl_i.a_address[TL_AW-1:2], 2'b00};
  assign wdata_o = tl_i.a_data;
  assign be_o    = tl_i.a_mask;

  always_comb begin
    push_entry.d_opcode = is_get ? AccessAckData : AccessAck;
    push_entry.size     = tl_i.a_size;
    push_entry.source   = tl_i.a_source;
    push_entry.data     = (bad & is_get) ? '1 : '0;
    push_entry.err      = bad;
  end

  assign d_valid = rst_ni & head_done;
  assign pop     = d_valid & tl_i.d_ready;

  tlul_rsp_buf #(
    .Depth (Depth)
  ) u_rsp_buf (
    .clock         (clock),
    .rst_ni        (rst_ni),
    .push          (push),
    .push_entry    (push_entry),
    .push_done     (bad),
    .complete      (rvalid_i),
    .complete_data (rdata_i),
    .complete_err  (err_i),
    .pop           (pop),
    .full          (full),
    .pending       (pending),
    .head_done     (head_done),
    .head_entry    (head_entry)
  );

  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = a_ready;
    tl_o.d_valid  = d_valid;
    tl_o.d_opcode = head_entry.d_opcode;
    tl_o.d_size   = head_entry.size;
    tl_o.d_source = head_entry.source;
    tl_o.d_data   = head_entry.data;
    tl_o.d_error  = head_entry.err;
  end

  assign unused_fields = ^{tl_i.a_param, tl_i.a_user};

  // A device response with nothing outstanding means the device misbehaved.
  rvalid_has_target : assert property (@(posedge clock) disable iff (!rst_ni)
                                       rvalid_i |-> pending);

endmodule

// File: tb/tb_tlul_device_adapter.sv
// Scoreboard bench for tlul_device_adapter: directed scenarios plus random
// traffic, checked every cycle against a transaction-level reference model.
module tb_tlul_device_adapter;
  import tlul_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic        err;
    bit          resolved;
  } txn_t;

  logic        clock = 1'b0;
  logic        rst_ni;
  tl_h2d_t     tl_i;
  tl_h2d_t     host_a;
  logic        host_d_ready;
  tl_d2h_t     tl_o;
  logic        req_o, gnt_i, we_o, rvalid_i, err_i;
  logic [31:0] addr_o, wdata_o, rdata_i;
  logic [3:0]  be_o;

  logic        dev_gnt, dev_rvalid, dev_err, stray_rvalid;
  logic [31:0] dev_rdata;
  int          dev_mode = 1;
  int          dev_delay = 0;
  logic [31:0] dev_data = 32'hDEAD_BEEF;
  int          dev_granted = 0;
  int          dev_responded = 0;

  int          checks = 0;
  int          errors = 0;
  txn_t        model_q[$];

  always_comb begin
    tl_i         = host_a;
    tl_i.d_ready = host_d_ready;
  end

  assign gnt_i    = dev_gnt;
  assign rvalid_i = dev_rvalid | stray_rvalid;
  assign rdata_i  = dev_rdata;
  assign err_i    = dev_err;

  tlul_device_adapter #(
    .Depth (DEPTH)
  ) dut (
    .clock    (clock),
    .rst_ni   (rst_ni),
    .tl_i     (tl_i),
    .tl_o     (tl_o),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .we_o     (we_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .be_o     (be_o),
    .rvalid_i (rvalid_i),
    .rdata_i  (rdata_i),
    .err_i    (err_i)
  );

  initial forever #5 clock = ~clock;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Byte lanes covered by 2^size bytes starting at the given offset.
  function automatic logic [3:0] model_lanes(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] l;
    int first, nbytes;
    l = 4'h0;
    first = int'(off);
    nbytes = 1 << int'(size);
    for (int b = 0; b < 4; b++) begin
      if (b >= first && b < first + nbytes) l[b] = 1'b1;
    end
    return l;
  endfunction

  function automatic bit model_bad(input logic [2:0] op, input logic [1:0] size,
                                   input logic [31:0] addr, input logic [3:0] mask);
    logic [3:0] lanes;
    int nbytes;
    if (op != 3'd4 && op != 3'd0 && op != 3'd1) return 1'b1;
    if (size > 2'd2) return 1'b1;
    nbytes = 1 << int'(size);
    if ((int'(addr[1:0]) % nbytes) != 0) return 1'b1;
    lanes = model_lanes(size, addr[1:0]);
    if ((mask & ~lanes) != 4'h0) return 1'b1;
    if (op == 3'd0 && mask != lanes) return 1'b1;
    return 1'b0;
  endfunction

  // Device model: grants and answers granted requests in order.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    dev_gnt = 1'b0;
    dev_rvalid = 1'b0;
    dev_rdata = '0;
    dev_err = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      dev_rvalid = 1'b0;
      dev_rdata = $urandom;
      dev_err = 1'($urandom_range(1));
      dev_gnt = (dev_mode == 0) ? ($urandom_range(3) != 0) : 1'b1;
      if (rst_ni && (dev_granted - dev_responded) > 0) begin
        if (dev_mode == 0) begin
          if ($urandom_range(2) == 0) begin
            dev_rvalid = 1'b1;
            dev_err = ($urandom_range(7) == 0);
            dev_responded++;
          end
        end else if (wait_cnt >= dev_delay) begin
          dev_rvalid = 1'b1;
          dev_rdata = dev_data;
          dev_err = 1'b0;
          dev_responded++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor and scoreboard: every cycle predicts handshakes and D-channel
  // contents from the model, then applies the cycle's events to it.
  initial begin
    txn_t t;
    bit full_now, bad_now, exp_dv;
    forever begin
      @(negedge clock);
      if (!rst_ni) begin
        check_output("rst_a_ready", 64'(tl_o.a_ready), 64'(0));
        check_output("rst_d_valid", 64'(tl_o.d_valid), 64'(0));
        check_output("rst_req", 64'(req_o), 64'(0));
        model_q.delete();
        dev_granted = dev_responded;
      end else begin
        full_now = (model_q.size() >= DEPTH);
        exp_dv = (model_q.size() > 0) && model_q[0].resolved;
        check_output("d_valid", 64'(tl_o.d_valid), 64'(exp_dv));
        if (tl_o.d_valid && exp_dv) begin
          t = model_q[0];
          check_output("d_fields",
                       64'({tl_o.d_opcode, tl_o.d_size, tl_o.d_source, tl_o.d_data, tl_o.d_error}),
                       64'({t.op, t.size, t.source, t.data, t.err}));
          check_output("d_zero", 64'({tl_o.d_param, tl_o.d_sink, tl_o.d_user}), 64'(0));
          if (tl_i.d_ready) void'(model_q.pop_front());
        end
        if (rvalid_i) begin
          for (int i = 0; i < model_q.size(); i++) begin
            if (!model_q[i].resolved) begin
              model_q[i].data = (model_q[i].op == 3'd1) ? rdata_i : 32'h0;
              model_q[i].err = err_i;
              model_q[i].resolved = 1'b1;
              break;
            end
          end
        end
        if (host_a.a_valid) begin
          bad_now = model_bad(host_a.a_opcode, host_a.a_size, host_a.a_address, host_a.a_mask);
          check_output("a_ready", 64'(tl_o.a_ready), 64'(!full_now && (bad_now || gnt_i)));
          check_output("req", 64'(req_o), 64'(!full_now && !bad_now));
          if (req_o) begin
            check_output("down_req", 64'({we_o, addr_o, be_o}),
                         64'({host_a.a_opcode != 3'd4, host_a.a_address & ~32'h3, host_a.a_mask}));
            check_output("down_wdata", 64'(wdata_o), 64'(host_a.a_data));
          end
          if (tl_o.a_ready) begin
            t.op = (host_a.a_opcode == 3'd4) ? 3'd1 : 3'd0;
            t.size = host_a.a_size;
            t.source = host_a.a_source;
            t.err = bad_now;
            t.data = (bad_now && host_a.a_opcode == 3'd4) ? 32'hFFFF_FFFF : 32'h0;
            t.resolved = bad_now;
            model_q.push_back(t);
          end
        end else begin
          check_output("req_idle", 64'(req_o), 64'(0));
        end
        if (req_o && gnt_i) dev_granted++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present one request and hold it until accepted or the budget runs out.
  task automatic apply_stimulus(input logic [2:0] op, input logic [1:0] size,
                                input logic [31:0] addr, input logic [3:0] mask,
                                input logic [7:0] src, input logic [31:0] data);
    bit accepted;
    accepted = 1'b0;
    host_a.a_valid = 1'b1;
    host_a.a_opcode = op;
    host_a.a_size = size;
    host_a.a_address = addr;
    host_a.a_mask = mask;
    host_a.a_source = src;
    host_a.a_data = data;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock);
      if (tl_o.a_ready) accepted = 1'b1;
      @(posedge clock);
      #1;
    end
    host_a.a_valid = 1'b0;
    if (!accepted) check_output("accept_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    int r;
    logic [31:0] r32;
    logic [2:0] op;
    logic [1:0] size;
    rst_ni = 1'b0;
    host_a = '0;
    host_d_ready = 1'b0;
    stray_rvalid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rst_ni = 1'b1;
    host_d_ready = 1'b1;
    idle(2);

    $display("[TB] single Get and PutPartialData");
    apply_stimulus(3'd4, 2'd2, 32'h100, 4'hF, 8'h5A, 32'h0);
    idle(4);
    apply_stimulus(3'd1, 2'd1, 32'h102, 4'hC, 8'h11, 32'h1234_0000);
    idle(4);

    $display("[TB] illegal requests");
    apply_stimulus(3'd2, 2'd2, 32'h200, 4'hF, 8'h01, 32'h0);
    apply_stimulus(3'd4, 2'd2, 32'h101, 4'hF, 8'h02, 32'h0);
    apply_stimulus(3'd0, 2'd1, 32'h200, 4'h1, 8'h03, 32'hABCD);
    apply_stimulus(3'd4, 2'd2, 32'h103, 4'h8, 8'h04, 32'h0);
    idle(4);

    $display("[TB] back-pressure");
    host_d_ready = 1'b0;
    apply_stimulus(3'd4, 2'd2, 32'h300, 4'hF, 8'h21, 32'h0);
    apply_stimulus(3'd4, 2'd2, 32'h304, 4'hF, 8'h22, 32'h0);
    fork
      apply_stimulus(3'd4, 2'd2, 32'h308, 4'hF, 8'h23, 32'h0);
      begin
        repeat (8) @(posedge clock);
        #1;
        host_d_ready = 1'b1;
      end
    join
    idle(6);

    $display("[TB] interleave");
    dev_delay = 5;
    apply_stimulus(3'd4, 2'd2, 32'h400, 4'hF, 8'h31, 32'h0);
    apply_stimulus(3'd2, 2'd0, 32'h400, 4'h1, 8'h32, 32'h0);
    idle(12);

    $display("[TB] reset mid-flight");
    dev_delay = 20;
    host_d_ready = 1'b0;
    apply_stimulus(3'd4, 2'd2, 32'h500, 4'hF, 8'h41, 32'h0);
    apply_stimulus(3'd4, 2'd2, 32'h504, 4'hF, 8'h42, 32'h0);
    idle(2);
    rst_ni = 1'b0;
    stray_rvalid = 1'b1;
    host_a.a_valid = 1'b1;
    host_a.a_opcode = 3'd4;
    host_a.a_size = 2'd2;
    host_a.a_address = 32'h600;
    host_a.a_mask = 4'hF;
    @(posedge clock);
    #1;
    rst_ni = 1'b1;
    stray_rvalid = 1'b0;
    host_a.a_valid = 1'b0;
    dev_delay = 0;
    host_d_ready = 1'b1;
    idle(2);
    apply_stimulus(3'd4, 2'd2, 32'h600, 4'hF, 8'h43, 32'h0);
    idle(4);

    $display("[TB] random traffic");
    dev_mode = 0;
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(9);
      op = (r < 4) ? 3'd4 : (r < 6) ? 3'd0 : (r < 8) ? 3'd1 : (r == 8) ? 3'd2 : 3'($urandom_range(7));
      size = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
      r32 = $urandom;
      if ($urandom_range(3) != 0) begin
        if (size == 2'd1) r32[0] = 1'b0;
        else if (size >= 2'd2) r32[1:0] = 2'b00;
      end
      host_a.a_valid = ($urandom_range(9) < 7);
      host_a.a_opcode = op;
      host_a.a_param = 3'($urandom_range(7));
      host_a.a_size = size;
      host_a.a_address = r32;
      host_a.a_mask = ($urandom_range(9) < 7) ? model_lanes(size, r32[1:0]) : 4'($urandom_range(15));
      host_a.a_source = 8'($urandom_range(255));
      host_a.a_data = $urandom;
      host_a.a_user = 4'($urandom_range(15));
      host_d_ready = ($urandom_range(9) < 7);
      @(posedge clock);
      #1;
    end

    host_a.a_valid = 1'b0;
    host_d_ready = 1'b1;
    for (int c = 0; c < 300 && model_q.size() > 0; c++) begin
      @(posedge clock);
      #1;
    end
    check_output("drain_empty", 64'(model_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlul_device_adapter.md
# tlul_device_adapter

TL-UL responder that terminates one TL-UL link on a device (memory, peripheral) exposing the simple req/gnt/rvalid interface the core uses toward its memories. Checks each A-channel request, forwards legal ones downstream, and tracks up to `Depth` outstanding requests. Returns in-order D-channel responses with full back-pressure support. It is the slave-side counterpart of the host adapters on the core's instruction and data ports, placed in front of SRAMs and register blocks on the crossbar.

## Interface
- `Depth`, 2, maximum outstanding accepted-but-unresponded requests; power of two, ≥2.
- `clock` input 1 — sole clock, rising edge.
- `rst_ni` input 1 — synchronous, active-low reset.
- `tl_i` input `tlul_pkg::tl_h2d_t` — A channel plus `d_ready` from the host.
- `tl_o` output `tlul_pkg::tl_d2h_t` — D channel plus `a_ready` to the host.
- `req_o` output 1 — downstream request valid.
- `gnt_i` input 1 — downstream accepted `req_o` this cycle.
- `we_o` output 1 — 1 for PutFullData/PutPartialData, 0 for Get.
- `addr_o` output 32 — `a_address` with bits [1:0] forced to 0.
- `wdata_o` output 32 — `a_data`.
- `be_o` output 4 — `a_mask`.
- `rvalid_i` input 1 — downstream response for the oldest granted request.
- `rdata_i` input 32 — read data, qualified by `rvalid_i`.
- `err_i` input 1 — downstream error, qualified by `rvalid_i`.

## Operation
- **Legality check** (combinational on A): the request is erroneous if any of the following hold:
  - the opcode is not Get (4), PutFullData (0) or PutPartialData (1);
  - `a_size` > 2;
  - `a_address[1:0]` is not aligned to 2^`a_size`;
  - a `a_mask` bit is set outside the lanes selected by size/offset;
  - the opcode is PutFullData and `a_mask` ≠ exactly those lanes.
- **Entry buffer:** circular, `Depth` entries. Each entry holds `d_opcode` (AccessAckData=1 for Get, AccessAck=0 otherwise), `size`, `source`, `data[31:0]`, `err`, and `done`. Pointers `wr_ptr`/`rd_ptr` have one extra wrap bit; full when the MSBs differ and the low bits are equal.
- **Legal request:**
  - `req_o` = `a_valid & ~full & ~bad`; `a_ready` = `~full & (bad | gnt_i)`.
  - On `a_valid & a_ready` the request is pushed with `done=0`.
- **Erroneous request:**
  - Never drives `req_o`.
  - Accepted whenever not full and pushed with `done=1`, `err=1`, `data=32'hFFFF_FFFF` for Get, 0 for Put.
- **`rvalid_i`:** completes the oldest entry (scan from `rd_ptr`) with `done=0`. It stores `data` (`rdata_i` for Get, 0 for Put), sets `err=err_i` and `done=1`.
  - `rvalid_i` with no pending entry is a downstream protocol violation: ignored, with an assertion.
- **D channel:**
  - `d_valid` = head entry present and `done`.
  - `d_opcode`, `d_size`, `d_source`, `d_data` and `d_error` come from the head entry; `d_param`, `d_sink` and `d_user` are 0.
  - `d_valid & d_ready` pops the head.
- **Ordering:** responses leave strictly in acceptance order. A completed erroneous entry waits behind older pending ones.

## Timing
- **Reset** (`rst_ni`=0 at a clock edge): pointers and all `done` flags clear. For as long as `rst_ni`=0: `a_ready`=0, `d_valid`=0, `req_o`=0. Entries in flight are discarded; a later `rvalid_i` with an empty buffer is ignored.
- **Combinational paths:** `req_o`/`a_ready` are combinational from `tl_i` A fields, `gnt_i` and the registered full flag. There is no combinational path from `d_ready` or `rvalid_i` to any output.
- **Latency:** request accepted in cycle T, `rvalid_i` in cycle R ≥ T+1 → `d_valid` earliest in cycle R+1. An erroneous request accepted in T at the head gives `d_valid` in T+1.
- **When full:** a push is refused even if a pop occurs the same cycle. Full throughput needs `Depth` ≥ round-trip latency.
- **Simultaneous events:** push, `rvalid_i` completion and pop may all occur in one cycle. The completion then targets the oldest pending entry before the push.
- **Hold:** `d_valid` and all D fields stay stable until `d_ready`. The host may drop `a_valid` freely; the adapter makes no stability assumption on A.

## Structure
- Reuse the `tlul_pkg` structs and add the shared constants there if they are missing: opcode values (`Get`, `PutFullData`, `PutPartialData`, `AccessAck`, `AccessAckData`) and `TL_DW`/`TL_AW`.
- One sub-module `tlul_rsp_buf`: entry storage, pointers, full/empty, oldest-pending search, and push/complete/pop ports.
- The legality check and handshake glue stay in `tlul_device_adapter`.

## Test plan
- **Single Get:** addr 0x100, size 2, mask 0xF; device grants immediately, then `rvalid_i` next cycle with 0xDEADBEEF. Expected: AccessAckData, `d_data`=0xDEADBEEF, `d_error`=0, `d_source` echoed, `d_valid` 1 cycle after `rvalid_i`.
- **PutPartialData:** addr 0x102, size 1, mask 0xC. Expected: `req_o` with `we_o`=1, `addr_o`=0x100, `be_o`=0xC; on `rvalid_i`, AccessAck with `d_size`=1.
- **Illegal requests:** each is accepted with no `req_o`, and `d_error`=1 the next cycle:
  - opcode 2;
  - size 2 at addr 0x101;
  - PutFullData size 1 with mask 0x1;
  - a Get additionally returns `d_data`=0xFFFFFFFF.
- **Back-pressure:** `Depth`=2, hold `d_ready`=0 and issue 3 Gets. Expected: third `a_ready`=0 until the first pop; responses emerge in order with stable D fields.
- **Interleave:** legal Get (`rvalid_i` delayed 5 cycles) followed by an illegal request. Expected: the error response appears only after the Get response; `rvalid_i` completes the Get entry, not the error entry.
- **Reset mid-flight:** 2 outstanding, deassert `rst_ni` for 1 cycle. Expected: `a_ready`/`d_valid`/`req_o`=0 during reset, buffer empty afterwards, a stray `rvalid_i` is ignored, and a new Get completes normally.
